// File: rtl/tg_arb_pkg.sv
// Shared types and constants for the two-requester TG request arbiter.
package tg_arb_pkg;

    localparam int NUM_REQ = 2;

    // Read data returned to a requester whose transaction timed out.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/tg_arb_req_slot.sv
// One pending-request capture register. A request pulse is latched only
// while the slot is empty; clr empties it when the transaction retires.
module tg_arb_req_slot #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_req,
    input  logic            rd_req,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            clr,
    output logic            pending,
    output logic            is_wr,
    output logic [AW-1:0]   slot_addr,
    output logic [DW-1:0]   slot_wdata,
    output logic [DW/8-1:0] slot_wstrb
);

    logic            pend_q, pend_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;

    // Capture into an empty slot; a write wins over a simultaneous read.
    always_comb begin
        pend_d  = pend_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (clr) begin
            pend_d = 1'b0;
        end else if (!pend_q && (wr_req || rd_req)) begin
            pend_d  = 1'b1;
            wr_d    = wr_req;
            addr_d  = addr;
            wdata_d = wdata;
            wstrb_d = wstrb;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign pending    = pend_q;
    assign is_wr      = wr_q;
    assign slot_addr  = addr_q;
    assign slot_wdata = wdata_q;
    assign slot_wstrb = wstrb_q;

endmodule

// File: rtl/tg_req_arbiter.sv
// Round-robin arbiter folding two requesters onto one TG AXI master port.
// One transaction in flight at a time: IDLE (grant) -> ISSUE (tg pulse)
// -> WAIT (tg_op_ack) -> IDLE. Optional WAIT watchdog is enabled by
// defining TG_ARB_TIMEOUT_EN; without it WAIT never expires and s_err is 0.
module tg_req_arbiter
    import tg_arb_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                m_axi_aclk,
    input  logic                                m_axi_aresetn,
    input  logic [NUM_REQ-1:0]                  s_wr_req,
    input  logic [NUM_REQ-1:0]                  s_rd_req,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   s_addr,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0] s_wstrb,
    output logic [NUM_REQ-1:0]                  s_op_ack,
    output logic [NUM_REQ-1:0]                  s_err,
    output logic [AXI_DATA_WIDTH-1:0]           s_rdata,
    output logic                                tg_wr_req,
    output logic                                tg_rd_req,
    output logic [AXI_ADDR_WIDTH-1:0]           tg_addr,
    output logic [AXI_DATA_WIDTH-1:0]           tg_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]         tg_wstrb,
    input  logic                                tg_op_ack,
    input  logic [AXI_DATA_WIDTH-1:0]           tg_rdata
);

    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int SW = AXI_DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [NUM_REQ-1:0]         slot_pend;
    logic [NUM_REQ-1:0]         slot_wr;
    logic [NUM_REQ-1:0]         slot_clr;
    logic [NUM_REQ-1:0][AW-1:0] slot_addr;
    logic [NUM_REQ-1:0][DW-1:0] slot_wdata;
    logic [NUM_REQ-1:0][SW-1:0] slot_wstrb;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        tg_arb_req_slot #(.AW(AW), .DW(DW)) u_slot (
            .clk        (m_axi_aclk),
            .rst_n      (m_axi_aresetn),
            .wr_req     (s_wr_req[g]),
            .rd_req     (s_rd_req[g]),
            .addr       (s_addr[g*AW +: AW]),
            .wdata      (s_wdata[g*DW +: DW]),
            .wstrb      (s_wstrb[g*SW +: SW]),
            .clr        (slot_clr[g]),
            .pending    (slot_pend[g]),
            .is_wr      (slot_wr[g]),
            .slot_addr  (slot_addr[g]),
            .slot_wdata (slot_wdata[g]),
            .slot_wstrb (slot_wstrb[g])
        );
    end

    arb_state_e         state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic               tg_wr_req_q, tg_wr_req_d;
    logic               tg_rd_req_q, tg_rd_req_d;
    logic [AW-1:0]      tg_addr_q, tg_addr_d;
    logic [DW-1:0]      tg_wdata_q, tg_wdata_d;
    logic [SW-1:0]      tg_wstrb_q, tg_wstrb_d;
    logic [NUM_REQ-1:0] s_op_ack_q, s_op_ack_d;
    logic [DW-1:0]      s_rdata_q, s_rdata_d;
    logic               next_grant;

`ifdef TG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] TO_RDATA = DW'(TIMEOUT_RDATA);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] s_err_q, s_err_d;
`endif

    // With both slots pending the requester not served last wins.
    assign next_grant = (slot_pend == 2'b11) ? ~last_grant_q : slot_pend[1];

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tg_wr_req_d  = 1'b0;
        tg_rd_req_d  = 1'b0;
        tg_addr_d    = tg_addr_q;
        tg_wdata_d   = tg_wdata_q;
        tg_wstrb_d   = tg_wstrb_q;
        s_op_ack_d   = '0;
        s_rdata_d    = s_rdata_q;
        slot_clr     = '0;
`ifdef TG_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        s_err_d      = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|slot_pend) begin
                    grant_d     = next_grant;
                    state_d     = ST_ISSUE;
                    tg_wr_req_d = slot_wr[next_grant];
                    tg_rd_req_d = !slot_wr[next_grant];
                    tg_addr_d   = slot_addr[next_grant];
                    tg_wdata_d  = slot_wdata[next_grant];
                    tg_wstrb_d  = slot_wstrb[next_grant];
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef TG_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (tg_op_ack) begin
                    s_op_ack_d[grant_q] = 1'b1;
                    if (!slot_wr[grant_q]) begin
                        s_rdata_d = tg_rdata;
                    end
                    slot_clr[grant_q] = 1'b1;
                    last_grant_d      = grant_q;
                    state_d           = ST_IDLE;
`ifdef TG_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    s_op_ack_d[grant_q] = 1'b1;
                    s_err_d[grant_q]    = 1'b1;
                    s_rdata_d           = TO_RDATA;
                    slot_clr[grant_q]   = 1'b1;
                    last_grant_d        = grant_q;
                    state_d             = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            tg_wr_req_q  <= 1'b0;
            tg_rd_req_q  <= 1'b0;
            tg_addr_q    <= '0;
            tg_wdata_q   <= '0;
            tg_wstrb_q   <= '0;
            s_op_ack_q   <= '0;
            s_rdata_q    <= '0;
`ifdef TG_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            s_err_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tg_wr_req_q  <= tg_wr_req_d;
            tg_rd_req_q  <= tg_rd_req_d;
            tg_addr_q    <= tg_addr_d;
            tg_wdata_q   <= tg_wdata_d;
            tg_wstrb_q   <= tg_wstrb_d;
            s_op_ack_q   <= s_op_ack_d;
            s_rdata_q    <= s_rdata_d;
`ifdef TG_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            s_err_q      <= s_err_d;
`endif
        end
    end

    assign s_op_ack  = s_op_ack_q;
    assign s_rdata   = s_rdata_q;
    assign tg_wr_req = tg_wr_req_q;
    assign tg_rd_req = tg_rd_req_q;
    assign tg_addr   = tg_addr_q;
    assign tg_wdata  = tg_wdata_q;
    assign tg_wstrb  = tg_wstrb_q;
`ifdef TG_ARB_TIMEOUT_EN
    assign s_err     = s_err_q;
`else
    assign s_err     = '0;
`endif

endmodule

// File: doc/tg_req_arbiter.md
TG_REQ_ARBITER -- requirements
Module: tg_req_arbiter

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width of all addr buses.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; strobe width is AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, WAIT-state watchdog limit, used only under TG_ARB_TIMEOUT_EN.
REQ-004 SHALL have port m_axi_aclk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port m_axi_aresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port s_wr_req  input  2  per-requester write request pulse; bit i is requester i.
REQ-007 SHALL have port s_rd_req  input  2  per-requester read request pulse.
REQ-008 SHALL have port s_addr  input  2*AXI_ADDR_WIDTH  requester i address in slice i, valid on its request pulse.
REQ-009 SHALL have port s_wdata  input  2*AXI_DATA_WIDTH  requester write data, valid on its request pulse.
REQ-010 SHALL have port s_wstrb  input  2*AXI_DATA_WIDTH/8  requester write strobes, valid on its request pulse.
REQ-011 SHALL have port s_op_ack  output  2  one-cycle completion pulse to requester i.
REQ-012 SHALL have port s_err  output  2  timeout flag, valid with s_op_ack.
REQ-013 SHALL have port s_rdata  output  AXI_DATA_WIDTH  read data, valid with s_op_ack.
REQ-014 SHALL have ports tg_wr_req, tg_rd_req  output  1 each  request pulses to the downstream TG AXI master.
REQ-015 SHALL have ports tg_addr, tg_wdata, tg_wstrb  output  widths as above  downstream request fields, valid on the tg pulse.
REQ-016 SHALL have ports tg_op_ack  input  1  and tg_rdata  input  AXI_DATA_WIDTH  downstream completion and read data.

Function
REQ-017 SHALL capture each request pulse into a per-requester pending slot (type, addr, wdata, wstrb) on the same edge.
REQ-018 SHALL ignore request pulses from a requester whose slot is pending, including the completion cycle.
REQ-019 SHALL treat simultaneous s_wr_req[i] and s_rd_req[i] as a write.
REQ-020 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-021 IDLE: SHALL latch grant when any slot pending and go to ISSUE next cycle; else stay.
REQ-022 Grant SHALL be round-robin: with both pending, the requester not granted last wins; after reset requester 0 wins.
REQ-023 ISSUE: SHALL drive exactly one cycle of tg_wr_req or tg_rd_req with the granted slot fields, then WAIT.
REQ-024 WAIT: on tg_op_ack SHALL pulse s_op_ack[grant] on the next cycle, register s_rdata from tg_rdata (reads) or hold it (writes), clear the slot, update last-grant, go IDLE.
REQ-025 Request-to-tg pulse latency SHALL be 2 cycles from an idle arbiter; tg_op_ack-to-s_op_ack latency SHALL be 1 cycle.
REQ-026 SHALL ignore tg_op_ack outside WAIT.
REQ-027 tg_addr/tg_wdata/tg_wstrb SHALL hold their last issued value outside ISSUE.

Reset
REQ-028 On m_axi_aresetn low SHALL immediately force IDLE, clear slots, last-grant=1, and drive all outputs (s_op_ack, s_err, s_rdata, tg_*) to 0.
REQ-029 Reset mid-operation SHALL drop the in-flight transaction with no s_op_ack; reset is synchronously deasserted externally.

Configuration
REQ-030 With macro TG_ARB_TIMEOUT_EN defined SHALL count WAIT cycles and, at TIMEOUT_CYCLES without tg_op_ack, pulse s_op_ack[grant] with s_err[grant]=1, s_rdata=32'hDEAD_BEEF (truncated/zero-extended to AXI_DATA_WIDTH), clear the slot, go IDLE.
REQ-031 Without TG_ARB_TIMEOUT_EN SHALL wait in WAIT indefinitely, omit the counter, tie s_err to 0.

Structure
REQ-032 Package tg_arb_pkg SHALL hold the FSM state enum, requester count (2), and the timeout read-data constant.
REQ-033 Sub-module tg_arb_req_slot (one pending-request capture register) SHALL be instantiated once per requester.

Verification
REQ-034 Req0 write addr 0x10 data 0xA5A5A5A5 strb 0xF, tg_op_ack after 3 cycles -> single tg_wr_req with those fields 2 cycles after request, s_op_ack=2'b01 one cycle after tg_op_ack, s_err=0.
REQ-035 Req0 and req1 reads same cycle after reset, tg_rdata 0x11 then 0x22 -> req0 served first with s_rdata 0x11, then req1 with 0x22; next simultaneous pair serves req0 first again (last grant req1).
REQ-036 Req1 second pulse while pending -> ignored, exactly one tg_rd_req and one s_op_ack[1].
REQ-037 TG_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no tg_op_ack -> s_op_ack with s_err=1, s_rdata 0xDEADBEEF, 16 cycles into WAIT; late tg_op_ack ignored.
REQ-038 Reset asserted in WAIT -> outputs 0 immediately, no s_op_ack; fresh req0 read after release completes normally.
